// File: rtl/reg_file_wb_pkg.sv
// Shared constants and types for the register file with write-back staging.
package reg_file_wb_pkg;

  localparam int DATA_W = 8;
  localparam int NREG   = 4;
  localparam int ADDR_W = 2;

  localparam logic [DATA_W-1:0] RESET_VAL = '0;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_PEND = 1'b1
  } wb_state_e;

endpackage

// File: rtl/reg_file_wb_wb_stage.sv
// One-entry write-back register: holds the staged write and flags read-port
// address matches so the top can forward the pending value.
module wb_stage
  import reg_file_wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output wb_state_e         wb_state,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              match1,
  output logic              match2
);

  wb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WB_IDLE;
      addr_q  <= '0;
      data_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // RegWrite is a one-cycle valid with no ready: every request is accepted,
  // and a PEND entry commits on the same edge that captures the next one.
  always_comb begin
    state_d = reg_write ? WB_PEND : WB_IDLE;
    addr_d  = addr_q;
    data_d  = data_q;
    if (reg_write) begin
      addr_d = write_reg;
      data_d = write_data;
    end
  end

  always_comb begin
    wb_state = state_q;
    wb_addr  = addr_q;
    wb_data  = data_q;
    match1   = (state_q == WB_PEND) && (addr_q == rd_addr1);
    match2   = (state_q == WB_PEND) && (addr_q == rd_addr2);
  end

endmodule

// File: rtl/reg_file_wb.sv
// Register file feeding the ALU operands; results are staged one cycle in
// wb_stage and forwarded to the read ports until they commit.
module reg_file_wb
  import reg_file_wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] Readreg1,
  input  logic [ADDR_W-1:0] Readreg2,
  input  logic [ADDR_W-1:0] Writereg,
  input  logic [DATA_W-1:0] Writedata,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] Readdata1,
  output logic [DATA_W-1:0] Readdata2,
  input  logic [ADDR_W-1:0] Dbgreg,
  output logic [DATA_W-1:0] Dbgdata,
  output logic              Wb_pending
);

  wb_state_e         wb_state;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              match1;
  logic              match2;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  wb_stage u_wb_stage (
    .clk        (clk),
    .reset_n    (reset_n),
    .reg_write  (RegWrite),
    .write_reg  (Writereg),
    .write_data (Writedata),
    .rd_addr1   (Readreg1),
    .rd_addr2   (Readreg2),
    .wb_state   (wb_state),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .match1     (match1),
    .match2     (match2)
  );

  always_comb begin
    regs_d = regs_q;
    if (wb_state == WB_PEND) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= RESET_VAL;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Only the staged write is forwarded; Writedata never reaches the read
  // ports combinationally, so no loop forms through the ALU.
  always_comb begin
    Readdata1  = match1 ? wb_data : regs_q[Readreg1];
    Readdata2  = match2 ? wb_data : regs_q[Readreg2];
    Dbgdata    = regs_q[Dbgreg];
    Wb_pending = (wb_state == WB_PEND);
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: the driver queues expected outputs per
// cycle and a negedge monitor pops and compares them.
module tb_reg_file_wb;

  logic       clk;
  logic       reset_n;
  logic [1:0] Readreg1, Readreg2, Writereg, Dbgreg;
  logic [7:0] Writedata;
  logic       RegWrite;
  logic [7:0] Readdata1, Readdata2, Dbgdata;
  logic       Wb_pending;

  localparam logic [1:0] S_RD1 = 2'd0;
  localparam logic [1:0] S_RD2 = 2'd1;
  localparam logic [1:0] S_DBG = 2'd2;
  localparam logic [1:0] S_PND = 2'd3;

  logic [9:0] exp_q[$];
  string      name_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  reg_file_wb dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Readreg1   (Readreg1),
    .Readreg2   (Readreg2),
    .Writereg   (Writereg),
    .Writedata  (Writedata),
    .RegWrite   (RegWrite),
    .Readdata1  (Readdata1),
    .Readdata2  (Readdata2),
    .Dbgreg     (Dbgreg),
    .Dbgdata    (Dbgdata),
    .Wb_pending (Wb_pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running, need done");
    $fatal(1, "timeout");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [9:0] e;
      logic [7:0] act;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (e[9:8])
        S_RD1:   act = Readdata1;
        S_RD2:   act = Readdata2;
        S_DBG:   act = Dbgdata;
        default: act = {7'd0, Wb_pending};
      endcase
      n_tests++;
      if (act !== e[7:0]) begin
        n_fail++;
        $display("FAIL %s: got 0x%02h, need 0x%02h (t=%0t)", nm, act, e[7:0], $time);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [1:0] sel, input logic [7:0] val, input string nm);
    exp_q.push_back({sel, val});
    name_q.push_back(nm);
  endtask

  task automatic set_wr(input logic we, input logic [1:0] wr, input logic [7:0] wd);
    RegWrite  = we;
    Writereg  = wr;
    Writedata = wd;
  endtask

  task automatic set_rd(input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] dbg);
    Readreg1 = r1;
    Readreg2 = r2;
    Dbgreg   = dbg;
  endtask

  initial begin
    reset_n = 1'b0;
    set_wr(1'b0, 2'd0, 8'h00);
    set_rd(2'd0, 2'd0, 2'd0);
    #1;
    expect_out(S_PND, 8'h00, "in_reset_pending");
    expect_out(S_RD1, 8'h00, "in_reset_rd1");
    step();
    step();
    reset_n = 1'b1;

    // reset state on every index
    for (int i = 0; i < 4; i++) begin
      set_rd(2'(i), 2'(i), 2'(i));
      expect_out(S_RD1, 8'h00, "reset_rd1");
      expect_out(S_RD2, 8'h00, "reset_rd2");
      expect_out(S_DBG, 8'h00, "reset_dbg");
      expect_out(S_PND, 8'h00, "reset_pending");
      step();
    end

    // single write with forwarding, then commit
    set_wr(1'b1, 2'd2, 8'h5A);
    set_rd(2'd2, 2'd0, 2'd2);
    expect_out(S_PND, 8'h00, "w1_c1_pending");
    expect_out(S_RD1, 8'h00, "w1_c1_no_fwd_current");
    step();
    set_wr(1'b0, 2'd0, 8'h00);
    expect_out(S_RD1, 8'h5A, "w1_c2_fwd_rd1");
    expect_out(S_DBG, 8'h00, "w1_c2_dbg_uncommitted");
    expect_out(S_PND, 8'h01, "w1_c2_pending");
    step();
    expect_out(S_RD1, 8'h5A, "w1_c3_rd1");
    expect_out(S_DBG, 8'h5A, "w1_c3_dbg_committed");
    expect_out(S_PND, 8'h00, "w1_c3_pending");
    step();

    // dependent chain on r1
    set_wr(1'b1, 2'd1, 8'h03);
    set_rd(2'd0, 2'd1, 2'd1);
    expect_out(S_RD2, 8'h00, "chain_c1_rd2");
    step();
    set_wr(1'b1, 2'd1, 8'h07);
    expect_out(S_RD2, 8'h03, "chain_c2_rd2_fwd");
    expect_out(S_DBG, 8'h00, "chain_c2_dbg");
    step();
    set_wr(1'b0, 2'd0, 8'h00);
    expect_out(S_RD2, 8'h07, "chain_c3_rd2_fwd_newer");
    expect_out(S_DBG, 8'h03, "chain_c3_dbg_older");
    expect_out(S_PND, 8'h01, "chain_c3_pending");
    step();
    expect_out(S_RD2, 8'h07, "chain_c4_rd2");
    expect_out(S_DBG, 8'h07, "chain_c4_dbg_final");
    expect_out(S_PND, 8'h00, "chain_c4_pending");
    step();

    // different-register burst
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, 2'(i), 8'h11 * 8'(i + 1));
      if (i > 0) begin
        set_rd(2'(i - 1), 2'(i), 2'd0);
        expect_out(S_PND, 8'h01, "burst_pending");
        expect_out(S_RD1, 8'h11 * 8'(i), "burst_fwd_prev");
      end
      step();
    end
    set_wr(1'b0, 2'd0, 8'h00);
    set_rd(2'd3, 2'd0, 2'd0);
    expect_out(S_PND, 8'h01, "burst_tail_pending");
    expect_out(S_RD1, 8'h44, "burst_tail_fwd");
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      set_rd(2'd0, 2'd0, 2'(i));
      expect_out(S_DBG, 8'h11 * 8'(i + 1), "burst_dbg");
      expect_out(S_PND, 8'h00, "burst_idle_pending");
      step();
    end

    // asynchronous reset with a write staged
    set_wr(1'b1, 2'd3, 8'hFF);
    set_rd(2'd3, 2'd0, 2'd3);
    step();
    set_wr(1'b0, 2'd0, 8'h00);
    #2;
    reset_n = 1'b0;
    #1;
    expect_out(S_PND, 8'h00, "rst_mid_pending");
    expect_out(S_RD1, 8'h00, "rst_mid_rd1");
    expect_out(S_DBG, 8'h00, "rst_mid_dbg");
    step();
    reset_n = 1'b1;
    expect_out(S_DBG, 8'h00, "rst_after_dbg_r3");
    expect_out(S_RD1, 8'h00, "rst_after_rd1_r3");
    expect_out(S_PND, 8'h00, "rst_after_pending");
    step();
    expect_out(S_DBG, 8'h00, "rst_after2_dbg_r3");
    step();

    // both ports on the same index
    set_wr(1'b1, 2'd2, 8'h80);
    step();
    set_wr(1'b0, 2'd0, 8'h00);
    set_rd(2'd2, 2'd2, 2'd2);
    expect_out(S_RD1, 8'h80, "dual_fwd_rd1");
    expect_out(S_RD2, 8'h80, "dual_fwd_rd2");
    step();
    expect_out(S_RD1, 8'h80, "dual_rd1");
    expect_out(S_RD2, 8'h80, "dual_rd2");
    expect_out(S_DBG, 8'h80, "dual_dbg");
    step();
    set_rd(2'd2, 2'd0, 2'd0);
    expect_out(S_RD1, 8'h80, "split_rd1");
    expect_out(S_RD2, 8'h00, "split_rd2");
    step();

    step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
